// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the F/D/E/M/W hazard controller.
// Holds the controller state enum, forwarding select codes and register address width.
package pipe_ctrl_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEMWAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Matches one decode source register against the E, M and W destinations.
// Ports: src_add/src_use (decode source), dest_*/we_* (producers), hit_* (per-stage match).
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src_add,
    input  logic              src_use,
    input  logic [REG_AW-1:0] dest_e,
    input  logic [REG_AW-1:0] dest_m,
    input  logic [REG_AW-1:0] dest_w,
    input  logic              we_e,
    input  logic              we_m,
    input  logic              we_w,
    output logic              hit_e,
    output logic              hit_m,
    output logic              hit_w
);

    // r0 is compared like any other register.
    assign hit_e = src_use && we_e && (dest_e == src_add);
    assign hit_m = src_use && we_m && (dest_m == src_add);
    assign hit_w = src_use && we_w && (dest_w == src_add);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: RAW stalls, branch flush, memory wait, stall counter.
// Ports: clk, reset (async, active-low); decode sources, E/M/W destinations,
//   branch_taken_e, mem_busy, perf_clr in; stallF/D/E, flushD/E, fwdSelA/B,
//   perf_stall_cnt, mem_timeout out. Macro FORWARDING_EN enables M/W forwarding.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] srcAddD1,
    input  logic [REG_AW-1:0] srcAddD2,
    input  logic              srcUseD1,
    input  logic              srcUseD2,
    input  logic [REG_AW-1:0] destAddE,
    input  logic [REG_AW-1:0] destAddM,
    input  logic [REG_AW-1:0] destAddW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemToRegE,
    input  logic              branch_taken_e,
    input  logic              mem_busy,
    input  logic              perf_clr,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        fwdSelA,
    output logic [1:0]        fwdSelB,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic              mem_timeout
);

    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       fl_cnt_q, fl_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic hit1_e, hit1_m, hit1_w;
    logic hit2_e, hit2_m, hit2_w;
    logic hz;
    logic [1:0] fwd_a, fwd_b;
    logic stall_f, stall_d, stall_e, flush_d, flush_e;

    hazard_cmp u_cmp1 (
        .src_add (srcAddD1),
        .src_use (srcUseD1),
        .dest_e  (destAddE),
        .dest_m  (destAddM),
        .dest_w  (destAddW),
        .we_e    (RegWriteE),
        .we_m    (RegWriteM),
        .we_w    (RegWriteW),
        .hit_e   (hit1_e),
        .hit_m   (hit1_m),
        .hit_w   (hit1_w)
    );

    hazard_cmp u_cmp2 (
        .src_add (srcAddD2),
        .src_use (srcUseD2),
        .dest_e  (destAddE),
        .dest_m  (destAddM),
        .dest_w  (destAddW),
        .we_e    (RegWriteE),
        .we_m    (RegWriteM),
        .we_w    (RegWriteW),
        .hit_e   (hit2_e),
        .hit_m   (hit2_m),
        .hit_w   (hit2_w)
    );

`ifdef FORWARDING_EN
    // Only a load in E cannot be forwarded in time.
    assign hz = MemToRegE && (hit1_e || hit2_e);
    assign fwd_a = hit1_m ? FWD_M : (hit1_w ? FWD_W : FWD_RF);
    assign fwd_b = hit2_m ? FWD_M : (hit2_w ? FWD_W : FWD_RF);
`else
    // W is write-through, so only E and M producers block decode.
    logic unused_fwd;
    assign hz = hit1_e || hit1_m || hit2_e || hit2_m;
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
    assign unused_fwd = ^{hit1_w, hit2_w, MemToRegE};
`endif

    always_comb begin
        state_d    = state_q;
        fl_cnt_d   = fl_cnt_q;
        wait_cnt_d = '0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    state_d    = MEMWAIT;
                    wait_cnt_d = 8'd1;
                end else if (branch_taken_e) begin
                    // Any hazard this cycle is on the wrong path.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d  = REDIRECT;
                        fl_cnt_d = FL_INIT;
                    end
                end else if (hz) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            REDIRECT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (mem_busy) begin
                    stall_f = 1'b1;
                end else begin
                    fl_cnt_d = fl_cnt_q - 3'd1;
                    if (fl_cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MEMWAIT: begin
                if (mem_busy) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX
                                                          : wait_cnt_q + 8'd1;
                end else begin
                    // Release cycle behaves like RUN but never enters REDIRECT.
                    state_d = RUN;
                    if (branch_taken_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (hz) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (perf_clr) begin
            cnt_d = '0;
            tmo_d = 1'b0;
        end else begin
            if (stall_f && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // wait_cnt_d is nonzero only while mem_busy holds the pipe.
            if (wait_cnt_d == WAIT_MAX) begin
                tmo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fl_cnt_q   <= '0;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fl_cnt_q   <= fl_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Control outputs are forced low while reset is asserted.
    assign stallF  = reset & stall_f;
    assign stallD  = reset & stall_d;
    assign stallE  = reset & stall_e;
    assign flushD  = reset & flush_d;
    assign flushE  = reset & flush_e;
    assign fwdSelA = reset ? fwd_a : FWD_RF;
    assign fwdSelB = reset ? fwd_b : FWD_RF;
    assign perf_stall_cnt = cnt_q;
    assign mem_timeout    = tmo_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus.
// A second instance with a 4-bit counter exercises stall-counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int MT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] srcAddD1, srcAddD2, destAddE, destAddM, destAddW;
    logic       srcUseD1, srcUseD2, RegWriteE, RegWriteM, RegWriteW;
    logic       MemToRegE, branch_taken_e, mem_busy, perf_clr;

    logic       stallF, stallD, stallE, flushD, flushE;
    logic [1:0] fwdSelA, fwdSelB;
    logic [15:0] cnt16;
    logic       tmo;

    logic       s_sF, s_sD, s_sE, s_fD, s_fE;
    logic [1:0] s_fa, s_fb;
    logic [3:0] cnt4;
    logic       tmo_s;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .srcAddD1(srcAddD1), .srcAddD2(srcAddD2),
        .srcUseD1(srcUseD1), .srcUseD2(srcUseD2),
        .destAddE(destAddE), .destAddM(destAddM), .destAddW(destAddW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .branch_taken_e(branch_taken_e),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .fwdSelA(fwdSelA), .fwdSelB(fwdSelB),
        .perf_stall_cnt(cnt16), .mem_timeout(tmo)
    );

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(4)
    ) dut_s (
        .clk(clk), .reset(reset),
        .srcAddD1(srcAddD1), .srcAddD2(srcAddD2),
        .srcUseD1(srcUseD1), .srcUseD2(srcUseD2),
        .destAddE(destAddE), .destAddM(destAddM), .destAddW(destAddW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .branch_taken_e(branch_taken_e),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .stallF(s_sF), .stallD(s_sD), .stallE(s_sE),
        .flushD(s_fD), .flushE(s_fE),
        .fwdSelA(s_fa), .fwdSelB(s_fb),
        .perf_stall_cnt(cnt4), .mem_timeout(tmo_s)
    );

    int n_run = 0;
    int n_fail = 0;

    // Model state: remaining flush cycles and length of the current memory hold.
    int redir_left, busy_run, m_cnt16, m_cnt4;
    bit m_tmo;
    bit e_sF, e_sD, e_sE, e_fD, e_fE;
    logic [1:0] e_fa, e_fb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        redir_left = 0;
        busy_run = 0;
        m_cnt16 = 0;
        m_cnt4 = 0;
        m_tmo = 0;
    endtask

    task automatic model_comb();
        bit h1e, h1m, h1w, h2e, h2m, h2w, hz;
        h1e = srcUseD1 && RegWriteE && destAddE == srcAddD1;
        h1m = srcUseD1 && RegWriteM && destAddM == srcAddD1;
        h1w = srcUseD1 && RegWriteW && destAddW == srcAddD1;
        h2e = srcUseD2 && RegWriteE && destAddE == srcAddD2;
        h2m = srcUseD2 && RegWriteM && destAddM == srcAddD2;
        h2w = srcUseD2 && RegWriteW && destAddW == srcAddD2;
        e_fa = h1m ? 2'b01 : (h1w ? 2'b10 : 2'b00);
        e_fb = h2m ? 2'b01 : (h2w ? 2'b10 : 2'b00);
`ifdef FORWARDING_EN
        hz = MemToRegE && (h1e || h2e);
`else
        hz = h1e || h1m || h2e || h2m;
        e_fa = 2'b00;
        e_fb = 2'b00;
`endif
        {e_sF, e_sD, e_sE, e_fD, e_fE} = 5'b0;
        if (redir_left > 0) begin
            e_fD = 1; e_fE = 1; e_sF = mem_busy;
        end else if (mem_busy) begin
            e_sF = 1; e_sD = 1; e_sE = 1;
        end else if (branch_taken_e) begin
            e_fD = 1; e_fE = 1;
        end else if (hz) begin
            e_sF = 1; e_sD = 1; e_fE = 1;
        end
    endtask

    task automatic model_update();
        if (perf_clr) begin
            m_cnt16 = 0;
            m_cnt4 = 0;
        end else if (e_sF) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (redir_left > 0) begin
            if (!mem_busy) redir_left--;
        end else if (mem_busy) begin
            busy_run++;
        end else begin
            if (branch_taken_e && busy_run == 0 && FC > 1) redir_left = FC - 1;
            busy_run = 0;
        end
        if (perf_clr) m_tmo = 0;
        else if (busy_run >= MT) m_tmo = 1;
    endtask

    task automatic cycle();
        #1;
        model_comb();
        chk("stallF", stallF, e_sF);
        chk("stallD", stallD, e_sD);
        chk("stallE", stallE, e_sE);
        chk("flushD", flushD, e_fD);
        chk("flushE", flushE, e_fE);
        chk("fwdSelA", fwdSelA, e_fa);
        chk("fwdSelB", fwdSelB, e_fb);
        @(posedge clk);
        model_update();
        #1;
        chk("perf_cnt", cnt16, m_cnt16);
        chk("perf_cnt4", cnt4, m_cnt4);
        chk("mem_timeout", tmo, m_tmo);
        chk("mem_timeout_s", tmo_s, m_tmo);
        @(negedge clk);
    endtask

    task automatic idle();
        srcAddD1 = 0; srcAddD2 = 0; destAddE = 0; destAddM = 0; destAddW = 0;
        srcUseD1 = 0; srcUseD2 = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; branch_taken_e = 0; mem_busy = 0; perf_clr = 0;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_stallF"}, stallF, 0);
        chk({tag, "_stallE"}, stallE, 0);
        chk({tag, "_flushD"}, flushD, 0);
        chk({tag, "_fwdA"}, fwdSelA, 0);
        chk({tag, "_cnt"}, cnt16, 0);
        chk({tag, "_tmo"}, tmo, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 0;
        model_reset();
        // Busy and a hazard during reset must not reach the outputs.
        mem_busy = 1;
        RegWriteM = 1; destAddM = 7; srcAddD1 = 7; srcUseD1 = 1;
        @(negedge clk);
        #1;
        check_reset_zero("rst");
        @(negedge clk);
        reset = 1;
        idle();

`ifdef FORWARDING_EN
        RegWriteE = 1; MemToRegE = 1; destAddE = 3; srcAddD1 = 3; srcUseD1 = 1;
        #1;
        chk("t1_stallF", stallF, 1);
        chk("t1_stallD", stallD, 1);
        chk("t1_flushE", flushE, 1);
        cycle();
        idle();
        RegWriteM = 1; destAddM = 3; srcAddD1 = 3; srcUseD1 = 1;
        #1;
        chk("t1_nostall", stallF, 0);
        chk("t1_fwdA", fwdSelA, 2'b01);
        cycle();
`else
        RegWriteM = 1; destAddM = 5; srcAddD2 = 5; srcUseD2 = 1;
        #1;
        chk("t2_stallF", stallF, 1);
        chk("t2_flushE", flushE, 1);
        chk("t2_stallE", stallE, 0);
        cycle();
        RegWriteM = 0; RegWriteW = 1; destAddW = 5;
        #1;
        chk("t2_release", stallF, 0);
        cycle();
`endif

        idle();
        branch_taken_e = 1;
        RegWriteE = 1; MemToRegE = 1; destAddE = 3; srcAddD1 = 3; srcUseD1 = 1;
        RegWriteM = 1; destAddM = 3;
        #1;
        chk("t3_flushD", flushD, 1);
        chk("t3_flushE", flushE, 1);
        chk("t3_nostall", stallF, 0);
        cycle();
        branch_taken_e = 0;
        #1;
        chk("t3_flushD2", flushD, 1);
        chk("t3_nostall2", stallF, 0);
        cycle();
        idle();
        #1;
        chk("t3_done", flushD, 0);
        cycle();

        perf_clr = 1;
        cycle();
        chk("t4_clr", cnt16, 0);
        perf_clr = 0;
        mem_busy = 1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk("t4_stallE", stallE, 1);
            cycle();
            chk("t4_tmo", tmo, (i >= 4) ? 1 : 0);
        end
        chk("t4_cnt", cnt16, 6);
        idle();
        #1;
        chk("t4_release", stallF, 0);
        cycle();

        mem_busy = 1;
        cycle();
        cycle();
        #2;
        reset = 0;
        #1;
        check_reset_zero("t5");
        model_reset();
        @(negedge clk);
        reset = 1;
        mem_busy = 0;
        branch_taken_e = 1;
        #1;
        chk("t5_flush", flushD, 1);
        cycle();
        branch_taken_e = 0;
        #1;
        chk("t5_redirect", flushD, 1);
        cycle();

        idle();
        perf_clr = 1;
        cycle();
        perf_clr = 0;
        mem_busy = 1;
        repeat (20) cycle();
        chk("t6_sat", cnt4, 15);
        chk("t6_cnt", cnt16, 20);
        perf_clr = 1;
        #1;
        chk("t6_stall", stallF, 1);
        cycle();
        chk("t6_clr", cnt4, 0);
        chk("t6_tmo_clr", tmo, 0);
        idle();
        cycle();

        for (int n = 0; n < 4000; n++) begin
            srcAddD1 = 4'($urandom_range(0, 3));
            srcAddD2 = 4'($urandom_range(0, 3));
            destAddE = 4'($urandom_range(0, 3));
            destAddM = 4'($urandom_range(0, 3));
            destAddW = 4'($urandom_range(0, 3));
            srcUseD1 = ($urandom_range(0, 3) != 0);
            srcUseD2 = ($urandom_range(0, 3) != 0);
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemToRegE = 1'($urandom_range(0, 1));
            branch_taken_e = ($urandom_range(0, 7) == 0);
            mem_busy = ($urandom_range(0, 7) == 0) ||
                       (mem_busy && $urandom_range(0, 4) != 0);
            perf_clr = ($urandom_range(0, 63) == 0);
            if (n % 1000 == 500) begin
                #2;
                reset = 0;
                #1;
                chk("rnd_rst_stallF", stallF, 0);
                chk("rnd_rst_cnt", cnt16, 0);
                model_reset();
                @(negedge clk);
                reset = 1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
